// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready load, per-bit valid and end-of-word marker.
// Emits one bit per enabled clock; a reload on the final bit streams words with no gap.
//
// state | meaning
// IDLE  | count == 0, nothing left to emit, ready for a word
// SHIFT | count != 0, bits remain; ready again only on the final bit
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             output_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             accept;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  assign in_ready = en && (count <= CW'(1));
  assign accept   = in_valid && in_ready;
  assign busy     = (count != '0);

  assign next_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      count      <= '0;
      output_bit <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (en) begin
      if (count != '0) begin
        output_bit <= next_bit;
        out_valid  <= 1'b1;
        out_last   <= (count == CW'(1));
      end else begin
        out_valid  <= 1'b0;
        out_last   <= 1'b0;
      end
      // A load on the final bit replaces the shift, but that bit is still emitted above.
      if (accept) begin
        shreg <= parallel_in;
        count <= CW'(WIDTH);
      end else if (count != '0) begin
        shreg <= shreg_shifted;
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB/LSB-first 8-bit, 12-bit and 1-bit builds side by side.
module tb_piso_serializer;

  logic clock = 1'b0;
  logic reset_n, en;

  logic [7:0]  din_m, din_l;
  logic [11:0] din_12;
  logic [0:0]  din_1;
  logic vld_m, vld_l, vld_12, vld_1;
  logic rdy_m, bit_m, ov_m, ol_m, busy_m;
  logic rdy_l, bit_l, ov_l, ol_l, busy_l;
  logic rdy_12, bit_12, ov_12, ol_12, busy_12;
  logic rdy_1, bit_1, ov_1, ol_1, busy_1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  seq8, seq8b;
  logic [15:0] seq16;
  logic [11:0] seq12;
  logic [4:0]  seq5;

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clock(clock), .reset_n(reset_n), .en(en), .parallel_in(din_m), .in_valid(vld_m),
    .in_ready(rdy_m), .output_bit(bit_m), .out_valid(ov_m), .out_last(ol_m), .busy(busy_m));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clock(clock), .reset_n(reset_n), .en(en), .parallel_in(din_l), .in_valid(vld_l),
    .in_ready(rdy_l), .output_bit(bit_l), .out_valid(ov_l), .out_last(ol_l), .busy(busy_l));

  piso_serializer #(.WIDTH(12), .MSB_FIRST(1'b1)) u_12 (
    .clock(clock), .reset_n(reset_n), .en(en), .parallel_in(din_12), .in_valid(vld_12),
    .in_ready(rdy_12), .output_bit(bit_12), .out_valid(ov_12), .out_last(ol_12), .busy(busy_12));

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_1 (
    .clock(clock), .reset_n(reset_n), .en(en), .parallel_in(din_1), .in_valid(vld_1),
    .in_ready(rdy_1), .output_bit(bit_1), .out_valid(ov_1), .out_last(ol_1), .busy(busy_1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0;
    din_m = '0; din_l = '0; din_12 = '0; din_1 = '0;
    vld_m = 1'b0; vld_l = 1'b0; vld_12 = 1'b0; vld_1 = 1'b0;
    #2;
    chk("rst_bit", bit_m, 0);
    chk("rst_valid", ov_m, 0);
    chk("rst_last", ol_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_ready_en_low", rdy_m, 0);
    chk("rst_ready_w1_en_low", rdy_1, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1; en = 1'b1;
    #1;
    chk("idle_ready", rdy_m, 1);
    chk("idle_ready_w1", rdy_1, 1);

    // 0x0F on MSB-first and LSB-first builds together
    tick;
    seq8  = 8'b0000_1111;
    seq8b = 8'b1111_0000;
    din_m = 8'h0F; din_l = 8'h0F; vld_m = 1'b1; vld_l = 1'b1;
    tick;
    vld_m = 1'b0; vld_l = 1'b0;
    chk("t1_busy_after_load", busy_m, 1);
    chk("t1_valid_after_load", ov_m, 0);
    chk("t1_ready_after_load", rdy_m, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("t1_bit", bit_m, seq8[7-i]);
      chk("t1_valid", ov_m, 1);
      chk("t1_last", ol_m, (i == 7));
      chk("t1_ready", rdy_m, (i >= 6));
      chk("t2_bit", bit_l, seq8b[7-i]);
      chk("t2_valid", ov_l, 1);
      chk("t2_last", ol_l, (i == 7));
    end
    tick;
    chk("t1_end_valid", ov_m, 0);
    chk("t1_end_last", ol_m, 0);
    chk("t1_end_busy", busy_m, 0);
    chk("t1_end_bit_hold", bit_m, 1);
    chk("t2_end_valid", ov_l, 0);

    // back-to-back 0xA5, 0x3C
    seq16 = 16'b1010_0101_0011_1100;
    chk("t3_idle_ready", rdy_m, 1);
    din_m = 8'hA5; vld_m = 1'b1;
    tick;
    din_m = 8'h3C;
    chk("t3_ready_after_load", rdy_m, 0);
    for (int j = 1; j <= 16; j++) begin
      tick;
      chk("t3_bit", bit_m, seq16[16-j]);
      chk("t3_valid", ov_m, 1);
      chk("t3_last", ol_m, (j == 8 || j == 16));
      chk("t3_ready", rdy_m, (j == 7 || j == 15 || j == 16));
      if (j == 8) vld_m = 1'b0;
    end
    tick;
    chk("t3_end_valid", ov_m, 0);

    // 0xF0 with a 3-cycle enable stall after the second bit
    seq8 = 8'b1111_0000;
    din_m = 8'hF0; vld_m = 1'b1;
    tick;
    vld_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("t4_pre_bit", bit_m, seq8[7-i]);
    end
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick;
      chk("t4_stall_bit", bit_m, 1);
      chk("t4_stall_valid", ov_m, 1);
      chk("t4_stall_last", ol_m, 0);
      chk("t4_stall_busy", busy_m, 1);
      chk("t4_stall_ready", rdy_m, 0);
      chk("t4_stall_ready_w1", rdy_1, 0);
    end
    en = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick;
      chk("t4_post_bit", bit_m, seq8[7-i]);
      chk("t4_post_valid", ov_m, 1);
      chk("t4_post_last", ol_m, (i == 7));
    end
    tick;
    chk("t4_end_valid", ov_m, 0);

    // reset pulse mid-word, then a clean 0x81
    din_m = 8'hFF; vld_m = 1'b1;
    tick;
    vld_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_pre_bit", bit_m, 1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_bit", bit_m, 0);
    chk("t5_async_valid", ov_m, 0);
    chk("t5_async_last", ol_m, 0);
    chk("t5_async_busy", busy_m, 0);
    #2;
    reset_n = 1'b1;
    seq8 = 8'b1000_0001;
    din_m = 8'h81; vld_m = 1'b1;
    tick;
    vld_m = 1'b0;
    chk("t5_reload_valid", ov_m, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("t5_bit", bit_m, seq8[7-i]);
      chk("t5_valid", ov_m, 1);
      chk("t5_last", ol_m, (i == 7));
    end
    tick;
    chk("t5_end_valid", ov_m, 0);

    // 12-bit build, 0xABC MSB-first
    seq12 = 12'b1010_1011_1100;
    din_12 = 12'hABC; vld_12 = 1'b1;
    tick;
    vld_12 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("t6_bit", bit_12, seq12[11-i]);
      chk("t6_valid", ov_12, 1);
      chk("t6_last", ol_12, (i == 11));
    end
    tick;
    chk("t6_end_valid", ov_12, 0);
    chk("t6_end_busy", busy_12, 0);

    // 1-bit build: accepts every enabled cycle, every bit is last
    seq5 = 5'b10110;
    din_1 = seq5[4]; vld_1 = 1'b1;
    tick;
    chk("t7_first_valid", ov_1, 0);
    chk("t7_first_ready", rdy_1, 1);
    din_1 = seq5[3];
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t7_bit", bit_1, seq5[4-i]);
      chk("t7_valid", ov_1, 1);
      chk("t7_last", ol_1, 1);
      chk("t7_ready", rdy_1, 1);
      if (i <= 2) din_1 = seq5[2-i];
      if (i == 3) vld_1 = 1'b0;
    end
    tick;
    chk("t7_end_valid", ov_1, 0);
    chk("t7_end_busy", busy_1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
